// File: rtl/johnson_seq_pkg.sv
// johnson_seq_pkg: shared state type, default geometry and the Johnson decode
// reference used by the ring controller's consistency check.
package johnson_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

   localparam int DEF_WIDTH = 4;
   localparam int STEPS     = 2 * DEF_WIDTH;

   // Johnson code at ring position idx: ones fill from the LSB for the first
   // half of the ring, then drain from the LSB for the second half.
   function automatic logic [63:0] decode(input int unsigned idx, input int unsigned width);
      logic [63:0] ones;
      ones = (64'd1 << width) - 64'd1;
      return idx <= width ? (64'd1 << idx) - 64'd1 : (ones << (idx - width)) & ones;
   endfunction

endpackage

// File: rtl/johnson_ring.sv
// johnson_ring: WIDTH-stage twisted-ring register with its ring position.
//   clk, reset (async active-low) ; en steps one position, dir 0=fwd 1=rev,
//   clr returns to position 0 (clr overrides en) ; phase, step_idx registered.
module johnson_ring #(
   parameter  int WIDTH = 4,
   localparam int IDX_W = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   output logic [WIDTH-1:0] phase,
   output logic [IDX_W-1:0] step_idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * WIDTH - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= '0;
         step_idx <= '0;
      end else if (clr) begin
         phase    <= '0;
         step_idx <= '0;
      end else if (en) begin
         phase    <= dir ? {~phase[0], phase[WIDTH-1:1]} : {phase[WIDTH-2:0], ~phase[WIDTH-1]};
         step_idx <= dir ? (step_idx == '0 ? LAST : step_idx - 1'b1)
                         : (step_idx == LAST ? '0 : step_idx + 1'b1);
      end
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson phase ring for a programmed number of
// rotations, with abort, completion pulse and corrupted-ring recovery.
//   clk, reset (async active-low) ; start/rotations/dir accepted in IDLE,
//   stop in RUN, err_clr in FAULT ; phase/step_idx from the ring,
//   busy (RUN), done (one-cycle completion), err (held in FAULT).
module johnson_seq_ctrl
   import johnson_seq_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int CNT_W = 8,
   localparam int IDX_W = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] rotations,
   input  logic             dir,
   input  logic             err_clr,
   output logic [WIDTH-1:0] phase,
   output logic [IDX_W-1:0] step_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state, state_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic             run_dir, run_dir_n;
   logic             en, clr, fault, wrap;

   johnson_ring #(.WIDTH(WIDTH)) u_ring (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .dir      (run_dir),
      .clr      (clr),
      .phase    (phase),
      .step_idx (step_idx)
   );

   // Ring register must always agree with the code its position implies.
   assign fault = phase != WIDTH'(decode(32'(step_idx), WIDTH));
   // The step taken this cycle lands on position 0 (a full rotation).
   assign wrap  = run_dir ? step_idx == IDX_W'(1) : step_idx == IDX_W'(2 * WIDTH - 1);

   assign busy = state == RUN;
   assign done = state == DONE;
   assign err  = state == FAULT;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rem     <= '0;
         run_dir <= 1'b0;
      end else begin
         state   <= state_n;
         rem     <= rem_n;
         run_dir <= run_dir_n;
      end
   end

   always_comb begin
      state_n   = state;
      rem_n     = rem;
      run_dir_n = run_dir;
      en        = 1'b0;
      clr       = 1'b0;
      if (fault) begin
         state_n = FAULT;
         clr     = 1'b1;
         rem_n   = '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state_n   = rotations != '0 ? RUN : DONE;
               rem_n     = rotations;
               run_dir_n = dir;
            end
            // The final wrap takes priority over a coincident stop.
            RUN: if (wrap && rem == CNT_W'(1)) begin
               en      = 1'b1;
               rem_n   = '0;
               state_n = DONE;
            end else if (stop) begin
               clr     = 1'b1;
               rem_n   = '0;
               state_n = IDLE;
            end else begin
               en    = 1'b1;
               rem_n = wrap ? rem - 1'b1 : rem;
            end
            DONE:    state_n = IDLE;
            FAULT:   state_n = err_clr ? IDLE : FAULT;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Controller that sequences a WIDTH-stage Johnson (twisted-ring) phase generator. It runs the ring for a programmed number of full rotations in either direction, then reports completion. It supports abort, and it detects and recovers from corrupted ring state. It sits between a host-side start/stop interface and the phase-consuming logic that the Johnson counter drives.

## Interface
Parameters:
- WIDTH, 4, number of Johnson stages; ring has 2*WIDTH states; WIDTH >= 2
- CNT_W, 8, width of the rotation-count field

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a run; sampled only in IDLE
- stop  input  1  abort request; sampled only in RUN
- rotations  input  CNT_W  number of full ring rotations; latched on the edge that accepts start
- dir  input  1  0 = forward, 1 = reverse; latched with rotations
- err_clr  input  1  clears the fault; sampled only in FAULT
- phase  output  WIDTH  current Johnson code driven to consumers
- step_idx  output  $clog2(2*WIDTH)  current position in the ring, 0..2*WIDTH-1
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a run completes
- err  output  1  sticky fault flag

## Operation
- Reset values, applied asynchronously while reset=0:
  - state=IDLE, phase=0, step_idx=0, busy=0, done=0, err=0
  - internal remaining-rotation counter = 0
- IDLE:
  - start=1 with rotations!=0: latch rotations and dir, go to RUN; phase stays 0.
  - start=1 with rotations==0: go to DONE directly.
- RUN, every cycle advances one step:
  - Forward: phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}, step_idx+1 mod 2*WIDTH.
  - Reverse: phase <= {~phase[0], phase[WIDTH-1:1]}, step_idx-1 mod 2*WIDTH.
  - Forward WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - Wrap: when the step returns phase to 0, remaining decrements. If remaining becomes 0, go to DONE.
  - stop=1: go to IDLE; phase and step_idx cleared; no done pulse.
  - stop=1 on the same edge as the final wrap: completion wins (DONE, done pulses).
- Fault check:
  - Every cycle outside reset, phase must equal decode(step_idx).
  - Mismatch in any state: go to FAULT, err=1, phase and step_idx cleared, busy=0.
- FAULT:
  - Holds until err_clr=1, then go to IDLE with err=0.
  - start, stop and rotations are ignored in FAULT.
- DONE:
  - done=1, busy=0, lasts exactly one cycle; next state is IDLE.
  - start in DONE is ignored.
- Width rules:
  - remaining is CNT_W bits and never underflows.
  - A run of R rotations takes exactly 2*WIDTH*R RUN cycles.

## Timing
- Counting from edge E0, the edge that accepts start (R≠0):
  - busy is high from after E0 through the edge E0+2*WIDTH*R.
  - At that edge phase=0, and done=1 for the following cycle.
- rotations==0: done=1 in the cycle after E0; busy never rises.
- Abort: stop sampled at edge Es; busy=0 and phase=0 after Es.
- Fault detection latency is one edge: a corrupt phase at edge Ef gives err=1 after Ef+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-run: outputs return to reset values immediately, without waiting for a clock edge; the next start begins from step 0.

## Structure
- Package johnson_seq_pkg:
  - state enum {IDLE, RUN, DONE, FAULT}
  - function decode(idx, WIDTH) returning the expected Johnson code
  - localparam STEPS = 2*WIDTH
- Sub-module johnson_ring:
  - WIDTH-bit twisted-ring register plus step_idx
  - inputs: en, dir, clr
  - outputs: phase, step_idx
- The controller FSM, the rotation counter and the fault compare live in johnson_seq_ctrl.

## Test plan
- Reset, then start with rotations=2, dir=0 (WIDTH=4) -> phase follows the forward sequence twice; busy high 16 cycles; done pulses once, on the cycle after the 16th step; phase=0000.
- start with rotations=1, dir=1 -> phase follows 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; step_idx 0, 7, 6, …, 1, 0; done after 8 cycles.
- Abort: start with rotations=3, assert stop at the 5th RUN cycle -> next cycle busy=0, phase=0000, no done. Then start with rotations=1 -> clean 8-cycle run.
- stop on the final-wrap edge with rotations=1 -> done pulses and busy drops.
- start with rotations=0 -> done=1 in the next cycle, busy stays 0.
- Force phase=0101 for one cycle in RUN:
  - expect err=1, state FAULT, phase=0000, and start ignored.
  - err_clr -> IDLE, err=0.
  - Assert reset low mid-run -> outputs zero immediately.
